// File: rtl/matrix_engine_pkg.sv
// Shared constants for the sequential matrix engine: opcodes, FSM state encoding and the
// default geometry.
package matrix_engine_pkg;

    localparam int unsigned DEF_DIM = 4;
    localparam int unsigned DEF_EW  = 16;

    localparam logic [2:0] OP_ADD       = 3'b010;
    localparam logic [2:0] OP_SUB       = 3'b011;
    localparam logic [2:0] OP_SCALE     = 3'b100;
    localparam logic [2:0] OP_MATMUL    = 3'b101;
    localparam logic [2:0] OP_TRANSPOSE = 3'b110;
    localparam logic [2:0] OP_MOVE      = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Opcodes 000 and 001 are reserved.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op[2:1] != 2'b00;
    endfunction

endpackage

// File: rtl/matrix_dot.sv
// Combinational unsigned dot product of two DIM-element vectors, element 0 in the LSBs.
// The sum is kept at full width so the caller can detect overflow.
module matrix_dot
    import matrix_engine_pkg::*;
#(
    parameter int unsigned DIM = DEF_DIM,
    parameter int unsigned EW  = DEF_EW,
    parameter int unsigned SW  = 2 * EW + $clog2(DIM)
) (
    input  logic [DIM*EW-1:0] i_a,
    input  logic [DIM*EW-1:0] i_b,
    output logic [SW-1:0]     o_sum
);

    always_comb begin
        o_sum = '0;
        for (int k = 0; k < DIM; k++) begin
            o_sum = o_sum + SW'(i_a[k*EW +: EW]) * SW'(i_b[k*EW +: EW]);
        end
    end

endmodule

// File: rtl/matrix_engine_seq.sv
// Sequential matrix engine: registers A, B, C with elementwise ops, scaling, transpose and
// move processed a row per cycle, and matrix multiply one element per cycle.
module matrix_engine_seq
    import matrix_engine_pkg::*;
#(
    parameter int unsigned DIM = DEF_DIM,
    parameter int unsigned EW  = DEF_EW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIM*DIM*EW-1:0] data_in,
    input  logic                  load_a,
    input  logic                  load_b,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [EW-1:0]         scalar,
    output logic                  busy,
    output logic                  done,
    output logic [DIM*DIM*EW-1:0] data_out,
    output logic                  out_valid,
    output logic                  ovf,
    output logic                  err
);

    localparam int unsigned CW = $clog2(DIM);
    localparam int unsigned SW = 2 * EW + CW;
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    logic [EW-1:0]     w_in      [DIM][DIM];
    logic [EW-1:0]     r_a       [DIM][DIM];
    logic [EW-1:0]     r_b       [DIM][DIM];
    logic [EW-1:0]     r_c       [DIM][DIM];
    state_t            r_state;
    logic [2:0]        r_op;
    logic [EW-1:0]     r_scalar;
    logic [CW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic              r_ovf;
    logic              r_valid;
    logic              r_err;
    logic [DIM*EW-1:0] w_dot_a   [DIM];
    logic [DIM*EW-1:0] w_dot_b   [DIM];
    logic [SW-1:0]     w_dot_sum [DIM];
    logic [EW-1:0]     w_row_res [DIM];
    logic              w_step_ovf;
    logic              w_last;

    for (genvar gr = 0; gr < DIM; gr++) begin : g_row
        for (genvar gc = 0; gc < DIM; gc++) begin : g_col
            assign w_in[gr][gc] = data_in[(DIM*DIM-1-(gr*DIM+gc))*EW +: EW];
            assign data_out[(DIM*DIM-1-(gr*DIM+gc))*EW +: EW] = r_c[gr][gc];
        end
    end

    // MATMUL uses lane 0 as row x column; SCALE uses every lane as a single-term product.
    for (genvar gj = 0; gj < DIM; gj++) begin : g_dot
        matrix_dot #(
            .DIM (DIM),
            .EW  (EW),
            .SW  (SW)
        ) u_dot (
            .i_a   (w_dot_a[gj]),
            .i_b   (w_dot_b[gj]),
            .o_sum (w_dot_sum[gj])
        );
    end

    always_comb begin
        for (int j = 0; j < DIM; j++) begin
            w_dot_a[j] = '0;
            w_dot_b[j] = '0;
        end
        if (r_op == OP_MATMUL) begin
            for (int k = 0; k < DIM; k++) begin
                w_dot_a[0][k*EW +: EW] = r_a[r_row][k];
                w_dot_b[0][k*EW +: EW] = r_b[k][r_col];
            end
        end else begin
            for (int j = 0; j < DIM; j++) begin
                w_dot_a[j][EW-1:0] = r_a[r_row][j];
                w_dot_b[j][EW-1:0] = r_scalar;
            end
        end
    end

    always_comb begin
        w_step_ovf = 1'b0;
        for (int c = 0; c < DIM; c++) begin
            w_row_res[c] = '0;
            case (r_op)
                OP_ADD: begin
                    w_row_res[c] = r_a[r_row][c] + r_b[r_row][c];
                    w_step_ovf   = w_step_ovf | (w_row_res[c] < r_a[r_row][c]);
                end
                OP_SUB: begin
                    w_row_res[c] = r_a[r_row][c] - r_b[r_row][c];
                    w_step_ovf   = w_step_ovf | (r_a[r_row][c] < r_b[r_row][c]);
                end
                OP_SCALE: begin
                    w_row_res[c] = w_dot_sum[c][EW-1:0];
                    w_step_ovf   = w_step_ovf | (|w_dot_sum[c][SW-1:EW]);
                end
                OP_TRANSPOSE: w_row_res[c] = r_a[c][r_row];
                OP_MOVE:      w_row_res[c] = r_c[r_row][c];
                default:      ;
            endcase
        end
        if (r_op == OP_MATMUL) begin
            w_step_ovf = |w_dot_sum[0][SW-1:EW];
        end
        w_last = (r_row == LAST) && ((r_op != OP_MATMUL) || (r_col == LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    r_a[r][c] <= '0;
                    r_b[r][c] <= '0;
                    r_c[r][c] <= '0;
                end
            end
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_scalar <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (op_is_legal(op)) begin
                            r_op     <= op;
                            r_scalar <= scalar;
                            r_row    <= '0;
                            r_col    <= '0;
                            r_ovf    <= 1'b0;
                            r_valid  <= 1'b0;
                            r_err    <= 1'b0;
                            r_state  <= ST_RUN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        for (int r = 0; r < DIM; r++) begin
                            for (int c = 0; c < DIM; c++) begin
                                if (load_a) r_a[r][c] <= w_in[r][c];
                                if (load_b) r_b[r][c] <= w_in[r][c];
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (r_op == OP_MATMUL) begin
                        r_c[r_row][r_col] <= w_dot_sum[0][EW-1:0];
                        if (r_col == LAST) begin
                            r_col <= '0;
                            r_row <= r_row + CW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end else begin
                        for (int c = 0; c < DIM; c++) begin
                            if (r_op == OP_MOVE) r_a[r_row][c] <= w_row_res[c];
                            else                 r_c[r_row][c] <= w_row_res[c];
                        end
                        r_row <= r_row + CW'(1);
                    end
                    r_ovf <= r_ovf | w_step_ovf;
                    if (w_last) begin
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced low for the whole time reset is held, not just after its first edge.
    assign busy      = !reset && (r_state == ST_RUN);
    assign done      = !reset && (r_state == ST_DONE);
    assign err       = done && r_err;
    assign out_valid = !reset && r_valid;
    assign ovf       = !reset && r_ovf;

endmodule
